// File: rtl/game_over_ctrl.sv
// game_over_ctrl: round controller for the Tom & Jerry game. It tracks the
// round timer, consecutive-frame collisions and cheese collected, decides the
// round outcome, and drives the 2-bit gameover code used by the overlay path.
//
// Ports:
//   clk          in   pixel clock
//   rst          in   synchronous active-high reset
//   reset        in   game restart pulse (returns to idle from any state)
//   start        in   round start pulse (only honoured in idle)
//   frame_tick   in   one-cycle pulse per frame (vblank start)
//   collision    in   Tom/Jerry overlap level, sampled on frame_tick only
//   cheese_eaten in   one-cycle pulse per cheese collected
//   gameover     out  00 playing/idle, 01 Tom wins, 10 Jerry wins, 11 draw
//   playing      out  high while a round is in progress
//   time_left    out  seconds remaining in the round
//   cheese_cnt   out  cheese collected this round
//
// Parameter ranges: ROUND_SECONDS 1..127, CATCH_FRAMES 1..15,
// CHEESE_TARGET 1..15, CLK_HZ >= 1.
module game_over_ctrl #(
  parameter int unsigned CLK_HZ        = 65_000_000,
  parameter int unsigned ROUND_SECONDS = 60,
  parameter int unsigned CATCH_FRAMES  = 4,
  parameter int unsigned CHEESE_TARGET = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       cheese_eaten,
  output logic [1:0] gameover,
  output logic       playing,
  output logic [6:0] time_left,
  output logic [3:0] cheese_cnt
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned TW = 7;
  localparam int unsigned CW = 4;

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_TOM   = 2'b01;
  localparam logic [1:0] GO_JERRY = 2'b10;
  localparam logic [1:0] GO_DRAW  = 2'b11;

  localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] TIME_INIT   = TW'(ROUND_SECONDS);
  localparam logic [CW-1:0] CATCH_LIMIT = CW'(CATCH_FRAMES);
  localparam logic [CW-1:0] CHEESE_GOAL = CW'(CHEESE_TARGET);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] catch_q, catch_d;
  logic [TW-1:0] time_q, time_d;
  logic [CW-1:0] cheese_q, cheese_d;
  logic [1:0]    go_q, go_d;
  logic          playing_q, playing_d;

  // Per-cycle events, only meaningful while in PLAY.
  logic wrap;
  logic catch_evt;
  logic cheese_evt;
  logic timeout_evt;

  // Next-state and counter logic; events are judged on the values the
  // counters take at this edge, so the outcome registers on the same edge.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    catch_d     = catch_q;
    time_d      = time_q;
    cheese_d    = cheese_q;
    go_d        = go_q;
    playing_d   = playing_q;
    wrap        = 1'b0;
    catch_evt   = 1'b0;
    cheese_evt  = 1'b0;
    timeout_evt = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PLAY;
          playing_d = 1'b1;
          presc_d   = '0;
          catch_d   = '0;
          cheese_d  = '0;
          time_d    = TIME_INIT;
          go_d      = GO_NONE;
        end
      end

      ST_PLAY: begin
        // One-second prescaler.
        wrap = (presc_q == PRESC_LAST);
        if (wrap) begin
          presc_d     = '0;
          time_d      = time_q - TW'(1);
          timeout_evt = (time_q == TW'(1));
        end else begin
          presc_d = presc_q + PW'(1);
        end

        // Consecutive collision frames, saturating at the catch threshold.
        if (frame_tick) begin
          if (collision) begin
            catch_d   = (catch_q == CATCH_LIMIT) ? catch_q : catch_q + CW'(1);
            catch_evt = (catch_d == CATCH_LIMIT);
          end else begin
            catch_d = '0;
          end
        end

        if (cheese_eaten) begin
          cheese_d   = cheese_q + CW'(1);
          cheese_evt = (cheese_d == CHEESE_GOAL);
        end

        if (catch_evt || cheese_evt || timeout_evt) begin
          state_d   = ST_OVER;
          playing_d = 1'b0;
          if (catch_evt && (cheese_evt || timeout_evt)) begin
            go_d = GO_DRAW;
          end else if (catch_evt) begin
            go_d = GO_TOM;
          end else begin
            go_d = GO_JERRY;
          end
        end
      end

      ST_OVER: begin
        playing_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Game restart wins over start and over any event in the same cycle.
    if (reset) begin
      state_d   = ST_IDLE;
      presc_d   = '0;
      catch_d   = '0;
      time_d    = TIME_INIT;
      cheese_d  = '0;
      go_d      = GO_NONE;
      playing_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      catch_q   <= '0;
      time_q    <= TIME_INIT;
      cheese_q  <= '0;
      go_q      <= GO_NONE;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      catch_q   <= catch_d;
      time_q    <= time_d;
      cheese_q  <= cheese_d;
      go_q      <= go_d;
      playing_q <= playing_d;
    end
  end

  assign gameover   = go_q;
  assign playing    = playing_q;
  assign time_left  = time_q;
  assign cheese_cnt = cheese_q;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Bench for game_over_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a round-level behavioural model.
module tb_game_over_ctrl;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned RS     = 3;
  localparam int unsigned CF     = 4;
  localparam int unsigned CT     = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic       collision;
  logic       cheese_eaten;
  logic [1:0] gameover;
  logic       playing;
  logic [6:0] time_left;
  logic [3:0] cheese_cnt;

  int checks = 0;
  int errors = 0;

  // Model: round phase flags, cycles elapsed in the round, collision run length.
  bit m_play;
  bit m_over;
  int m_elapsed;
  int m_run;
  int m_cheese;
  int m_time;
  int m_go;

  game_over_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .ROUND_SECONDS(RS),
    .CATCH_FRAMES (CF),
    .CHEESE_TARGET(CT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reset       (reset),
    .start       (start),
    .frame_tick  (frame_tick),
    .collision   (collision),
    .cheese_eaten(cheese_eaten),
    .gameover    (gameover),
    .playing     (playing),
    .time_left   (time_left),
    .cheese_cnt  (cheese_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs applied for that clock.
  task automatic model_step();
    bit caught;
    bit jerry;
    if (rst || reset) begin
      m_play = 0; m_over = 0; m_elapsed = 0; m_run = 0;
      m_cheese = 0; m_time = RS; m_go = 0;
    end else if (!m_play && !m_over) begin
      if (start) begin
        m_play = 1; m_elapsed = 0; m_run = 0; m_cheese = 0; m_time = RS; m_go = 0;
      end
    end else if (m_play) begin
      m_elapsed++;
      if (frame_tick) m_run = collision ? ((m_run < CF) ? m_run + 1 : CF) : 0;
      if (cheese_eaten) m_cheese++;
      m_time = RS - m_elapsed / CLK_HZ;
      caught = (m_run == CF);
      jerry  = (m_cheese == CT) || (m_time == 0);
      if (caught || jerry) begin
        m_go   = caught ? (jerry ? 3 : 1) : 2;
        m_play = 0;
        m_over = 1;
      end
    end
  endtask

  // One clock: model update, compare outputs 1 time unit after the edge, drop pulses.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("gameover", 32'(gameover), 32'(m_go));
    chk("playing", 32'(playing), 32'(m_play));
    chk("time_left", 32'(time_left), 32'(m_time));
    chk("cheese_cnt", 32'(cheese_cnt), 32'(m_cheese));
    reset = 0; start = 0; frame_tick = 0; cheese_eaten = 0;
  endtask

  initial begin
    rst = 1; reset = 0; start = 0; frame_tick = 0; collision = 0; cheese_eaten = 0;
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_time", 32'(time_left), 32'(RS));
    chk("rst_go", 32'(gameover), 32'd0);

    // Timeout round: 3 s at 10 cycles/s.
    start = 1; tick();
    chk("start_playing", 32'(playing), 32'd1);
    repeat (10) tick();
    chk("time_2", 32'(time_left), 32'd2);
    repeat (19) tick();
    chk("time_1_go", 32'(gameover), 32'd0);
    tick();
    chk("timeout_go", 32'(gameover), 32'd2);
    chk("timeout_playing", 32'(playing), 32'd0);
    chk("timeout_time", 32'(time_left), 32'd0);

    // Catch: four consecutive collision frames.
    reset = 1; tick();
    chk("reset_go", 32'(gameover), 32'd0);
    start = 1; tick();
    collision = 1;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1; tick();
      tick();
    end
    chk("catch_go", 32'(gameover), 32'd1);

    // Collision drops on the 3rd frame: run restarts.
    reset = 1; tick();
    start = 1; tick();
    collision = 1; frame_tick = 1; tick();
    frame_tick = 1; tick();
    collision = 0; frame_tick = 1; tick();
    collision = 1; frame_tick = 1; tick();
    frame_tick = 1; tick();
    collision = 0; frame_tick = 1; tick();
    chk("broken_run_go", 32'(gameover), 32'd0);
    tick();

    // Cheese win, then cheese and start in OVER are ignored.
    reset = 1; tick();
    start = 1; tick();
    for (int i = 0; i < 5; i++) begin
      cheese_eaten = 1; tick();
    end
    chk("cheese_cnt5", 32'(cheese_cnt), 32'd5);
    chk("cheese_go", 32'(gameover), 32'd2);
    for (int i = 0; i < 3; i++) begin
      cheese_eaten = 1; tick();
    end
    chk("cheese_over_cnt", 32'(cheese_cnt), 32'd5);
    start = 1; tick();
    chk("start_in_over", 32'(gameover), 32'd2);

    // Draw: 4th collision frame coincides with 5th cheese.
    reset = 1; tick();
    start = 1; tick();
    for (int i = 0; i < 4; i++) begin
      cheese_eaten = 1; tick();
    end
    collision = 1;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1; tick();
    end
    frame_tick = 1; cheese_eaten = 1; tick();
    chk("draw_go", 32'(gameover), 32'd3);

    // Reset from OVER, then a fresh round.
    reset = 1; tick();
    chk("rst_over_time", 32'(time_left), 32'(RS));
    chk("rst_over_cheese", 32'(cheese_cnt), 32'd0);
    start = 1; tick();
    chk("fresh_playing", 32'(playing), 32'd1);

    // Reset together with the catch-completing frame discards the catch.
    collision = 1;
    for (int i = 0; i < 3; i++) begin
      frame_tick = 1; tick();
    end
    frame_tick = 1; reset = 1; tick();
    chk("reset_catch_go", 32'(gameover), 32'd0);
    chk("reset_catch_playing", 32'(playing), 32'd0);
    collision = 0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(199) == 0);
      start        = ($urandom_range(19) == 0);
      frame_tick   = ($urandom_range(3) == 0);
      cheese_eaten = ($urandom_range(11) == 0);
      if ($urandom_range(2) == 0) collision = ~collision;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
